// File: rtl/jtopl_vib_pkg.sv
// jtopl_vib shared constants: vibrato depth codes and LFO step width.
// Imported by the LFO and the offset stage.
package jtopl_vib_pkg;

  localparam int LFO_W = 3;

  localparam logic [1:0] VIB_QUART = 2'd0;
  localparam logic [1:0] VIB_SHAL  = 2'd1;
  localparam logic [1:0] VIB_DEEP  = 2'd2;
  localparam logic [1:0] VIB_DBL   = 2'd3;

endpackage

// File: rtl/jtopl_vib_lfo.sv
// Vibrato LFO: sample prescaler plus 3-bit step counter.
// JTOPL_VIB_FAST_EN adds vib_fast, stepping on every sample.
module jtopl_vib_lfo
  import jtopl_vib_pkg::*;
#(
  parameter int DIVW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             zero,
`ifdef JTOPL_VIB_FAST_EN
  input  logic             vib_fast,
`endif
  output logic [LFO_W-1:0] vib_cnt
);

  localparam logic [DIVW-1:0]  PRE_ONE = 1;
  localparam logic [LFO_W-1:0] CNT_ONE = 1;

  logic [DIVW-1:0]  pre_q, pre_d;
  logic [LFO_W-1:0] cnt_q, cnt_d;
  logic             fast;

`ifdef JTOPL_VIB_FAST_EN
  assign fast = vib_fast;
`else
  assign fast = 1'b0;
`endif

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (cen && zero) begin
      if (fast) begin
        pre_d = '0;
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        pre_d = pre_q + PRE_ONE;
        if (&pre_q) cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign vib_cnt = cnt_q;

endmodule

// File: rtl/jtopl_vib.sv
// Vibrato engine: LFO plus registered signed phase-modulation offset.
// Optional macro JTOPL_VIB_FAST_EN adds the vib_fast test input.
module jtopl_vib
  import jtopl_vib_pkg::*;
#(
  parameter int FW   = 10,
  parameter int DIVW = 10,
  parameter int OW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             zero,
`ifdef JTOPL_VIB_FAST_EN
  input  logic             vib_fast,
`endif
  input  logic [FW-1:0]    fnum,
  input  logic [1:0]       vib_dep,
  input  logic             viben,
  output logic [LFO_W-1:0] vib_cnt,
  output logic [OW-1:0]    pm_offset
);

  logic [2:0]    base;
  logic [3:0]    base4;
  logic [3:0]    mag;
  logic [OW-1:0] mag_x;
  logic [OW-1:0] pm_d, pm_q;
  logic          unused_fnum;

  jtopl_vib_lfo #(
    .DIVW(DIVW)
  ) u_lfo (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .zero    (zero),
`ifdef JTOPL_VIB_FAST_EN
    .vib_fast(vib_fast),
`endif
    .vib_cnt (vib_cnt)
  );

  // only the top three F-number bits set the vibrato swing
  assign unused_fnum = ^fnum;
  assign base  = fnum[FW-1:FW-3] >> vib_cnt[0];
  assign base4 = {1'b0, base};

  always_comb begin
    mag = '0;
    unique case (vib_dep)
      VIB_QUART: mag = base4 >> 2;
      VIB_SHAL:  mag = base4 >> 1;
      VIB_DEEP:  mag = base4;
      VIB_DBL:   mag = base4 << 1;
    endcase
    if (vib_cnt[1:0] == 2'd0 || !viben) mag = '0;
  end

  assign mag_x = {{(OW-4){1'b0}}, mag};
  assign pm_d  = vib_cnt[2] ? -mag_x : mag_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pm_q <= '0;
    else if (cen) pm_q <= pm_d;
  end

  assign pm_offset = pm_q;

endmodule

// File: tb/tb_jtopl_vib.sv
// Self-checking bench for jtopl_vib against a sample-count model.
// Covers reset, depth table, prescaler boundary, cen hold, random traffic.
module tb_jtopl_vib;

  localparam int DIVW = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       zero = 1'b0;
  logic [9:0] fnum = '0;
  logic [1:0] vib_dep = '0;
  logic       viben = 1'b0;
  logic [2:0] vib_cnt;
  logic [4:0] pm_offset;
`ifdef JTOPL_VIB_FAST_EN
  logic       vib_fast = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int nz = 0;
  logic [4:0] exp_off = '0;

  always #5 clk = ~clk;

  jtopl_vib dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .zero     (zero),
`ifdef JTOPL_VIB_FAST_EN
    .vib_fast (vib_fast),
`endif
    .fnum     (fnum),
    .vib_dep  (vib_dep),
    .viben    (viben),
    .vib_cnt  (vib_cnt),
    .pm_offset(pm_offset)
  );

  task automatic check(string tag, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int step_of(int n);
    return (n / (1 << DIVW)) % 8;
  endfunction

  function automatic logic [4:0] offset_of(int f, int d, int en, int s);
    int b, m, v;
    b = (f / 128) / ((s % 2 == 1) ? 2 : 1);
    case (d)
      0:       m = b / 4;
      1:       m = b / 2;
      2:       m = b;
      default: m = b * 2;
    endcase
    if (s % 4 == 0 || en == 0) m = 0;
    v = (s >= 4) ? -m : m;
    return v[4:0];
  endfunction

  task automatic tick();
    if (rst_n && cen) begin
      exp_off = offset_of(int'(fnum), int'(vib_dep), int'(viben), step_of(nz));
      if (zero) nz++;
    end
    @(posedge clk);
    #1;
    check("vib_cnt", int'(vib_cnt), step_of(nz));
    check("pm_offset", int'(pm_offset), int'(exp_off));
  endtask

  task automatic pulse_to(int s);
    cen = 1'b1; zero = 1'b1; viben = 1'b0;
    for (int i = 0; i < 20000 && step_of(nz) != s; i++) tick();
    check("reach_step", step_of(nz), s);
  endtask

  task automatic probe(string tag, int d, int en, logic [4:0] want);
    fnum = 10'h380; vib_dep = d[1:0]; viben = en[0];
    cen = 1'b1; zero = 1'b0;
    tick();
    check(tag, int'(pm_offset), int'(want));
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    nz = 0; exp_off = '0;
    #1;
    check("async_rst_cnt", int'(vib_cnt), 0);
    check("async_rst_pm", int'(pm_offset), 0);
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cen = i[0]; zero = ~i[0]; fnum = 10'($urandom);
      viben = 1'b1; vib_dep = 2'd3;
      tick();
    end
    check("rst_cnt", int'(vib_cnt), 0);
    check("rst_pm", int'(pm_offset), 0);
    @(negedge clk);
    rst_n = 1'b1;

    cen = 1'b1; zero = 1'b1; viben = 1'b0;
    for (int i = 0; i < 1023; i++) tick();
    check("pre_1023", int'(vib_cnt), 0);
    tick();
    check("pre_1024", int'(vib_cnt), 1);
    for (int i = 1024; i < 8192; i++) tick();
    check("pre_8192", int'(vib_cnt), 0);

    pulse_to(1);
    probe("deep_s1", 2, 1, 5'b00011);
    pulse_to(2);
    probe("deep_s2", 2, 1, 5'b00111);
    probe("quart_s2", 0, 1, 5'b00001);
    probe("shal_s2", 1, 1, 5'b00011);
    probe("dbl_s2", 3, 1, 5'b01110);
    probe("viben0", 2, 0, 5'b00000);
    pulse_to(4);
    probe("deep_s4", 2, 1, 5'b00000);
    pulse_to(5);
    probe("deep_s5", 2, 1, 5'b11101);
    pulse_to(6);
    probe("dbl_s6", 3, 1, 5'b10010);
    pulse_to(0);
    probe("deep_s0", 2, 1, 5'b00000);

    probe("pre_hold", 3, 1, 5'b00000);
    pulse_to(6);
    probe("hold_set", 3, 1, 5'b10010);
    cen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      zero = i[0]; fnum = 10'($urandom); viben = 1'b1;
      tick();
    end
    check("hold_pm", int'(pm_offset), int'(5'b10010));
    check("hold_cnt", int'(vib_cnt), 6);

    async_reset();

`ifdef JTOPL_VIB_FAST_EN
    vib_fast = 1'b1; cen = 1'b1; zero = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      check("fast_step", int'(vib_cnt), i % 8);
    end
    vib_fast = 1'b0;
    async_reset();
`endif

    for (int i = 0; i < 20000; i++) begin
      cen = ($urandom_range(0, 3) != 0);
      zero = ($urandom_range(0, 9) != 0);
      fnum = 10'($urandom);
      vib_dep = 2'($urandom);
      viben = ($urandom_range(0, 3) != 0);
      tick();
      if (i == 9000) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
